// File: rtl/lcd_ctrl_pkg.sv
// Shared types and constants for the HD44780 LCD controller: FSM states,
// request record, CPU word bit positions and the power-on init command table.
package lcd_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_WAIT,
        ST_INIT
    } state_t;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } req_t;

    localparam int unsigned BIT_ON   = 31;
    localparam int unsigned BIT_TOG  = 10;
    localparam int unsigned BIT_RS   = 9;
    localparam int unsigned BIT_RW   = 8;
    localparam int unsigned DATA_MSB = 7;
    localparam int unsigned DATA_LSB = 0;

    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_AW    = 2;

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    // Element [0] is issued first.
    localparam int unsigned INIT_LEN = 4;
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    function automatic int unsigned phase_len(input int unsigned p);
        return (p == 0) ? 1 : p;
    endfunction

    function automatic logic is_long_cmd(input req_t r);
        return !r.rs && !r.rw && ((r.data == CMD_CLEAR) || (r.data == CMD_HOME));
    endfunction

endpackage

// File: rtl/lcd_ctrl_fifo.sv
// Four-entry request FIFO; the head is readable combinationally so the
// controller can pop and latch it in the same cycle.
module lcd_ctrl_fifo
    import lcd_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  req_t wr_data,
    output req_t rd_data,
    output logic full,
    output logic empty
);

    localparam logic [FIFO_AW:0] FULL_CNT = (FIFO_AW + 1)'(FIFO_DEPTH);

    req_t                 mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr;
    logic [FIFO_AW-1:0]   rd_ptr;
    logic [FIFO_AW:0]     count;
    logic                 do_push;
    logic                 do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (FIFO_AW + 1)'(1);
                2'b01:   count <= count - (FIFO_AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer fed by a toggle-handshake CPU register.
// Define LCD_CTRL_POWERON_INIT_EN to add the power-up wait and init sequence.
module lcd_ctrl
    import lcd_ctrl_pkg::*;
#(
    parameter int unsigned T_SETUP    = 4,
    parameter int unsigned T_PULSE    = 25,
    parameter int unsigned T_HOLD     = 2,
    parameter int unsigned T_GAP      = 2000,
    parameter int unsigned T_GAP_LONG = 82000,
    parameter int unsigned T_POWERUP  = 750000
)(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_word,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_overflow
);

    localparam int unsigned CNT_MAX = umax(umax(umax(T_SETUP, T_PULSE), umax(T_HOLD, T_GAP)),
                                           umax(umax(T_GAP_LONG, T_POWERUP), 1));
    localparam int unsigned CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] LD_SETUP    = CW'(phase_len(T_SETUP) - 1);
    localparam logic [CW-1:0] LD_PULSE    = CW'(phase_len(T_PULSE) - 1);
    localparam logic [CW-1:0] LD_HOLD     = CW'(phase_len(T_HOLD) - 1);
    localparam logic [CW-1:0] LD_GAP      = CW'(phase_len(T_GAP) - 1);
    localparam logic [CW-1:0] LD_GAP_LONG = CW'(phase_len(T_GAP_LONG) - 1);

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_next;
    req_t            out_q;
    req_t            out_next;
    logic            tog_q;
    logic            on_q;
    logic            ovf_q;

    req_t            req_in;
    req_t            head;
    logic            req_det;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;
    logic            unused_word_bits;

    assign unused_word_bits = ^i_lcd_word[BIT_ON-1:BIT_TOG+1];

    assign req_in  = {i_lcd_word[BIT_RS], i_lcd_word[BIT_RW], i_lcd_word[DATA_MSB:DATA_LSB]};
    assign req_det = (i_lcd_word[BIT_TOG] != tog_q);
    assign drop    = req_det && full && !pop;

    lcd_ctrl_fifo u_fifo (
        .clk     (i_clk),
        .reset   (i_reset),
        .push    (req_det),
        .pop     (pop),
        .wr_data (req_in),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

`ifdef LCD_CTRL_POWERON_INIT_EN
    localparam logic [CW-1:0] LD_POWERUP    = CW'(phase_len(T_POWERUP) - 1);
    localparam logic [2:0]    INIT_IDX_DONE = 3'(INIT_LEN);

    logic       pwr_done;
    logic       pwr_done_next;
    logic [2:0] init_idx;
    logic [2:0] init_idx_next;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pwr_done <= 1'b0;
            init_idx <= '0;
        end else begin
            pwr_done <= pwr_done_next;
            init_idx <= init_idx_next;
        end
    end

    // Masked by reset so the reset-state busy value stays low.
    assign o_busy = !empty || (state != ST_IDLE) || ((init_idx != INIT_IDX_DONE) && !i_reset);
`else
    assign o_busy = !empty || (state != ST_IDLE);
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        out_next   = out_q;
        pop        = 1'b0;
`ifdef LCD_CTRL_POWERON_INIT_EN
        pwr_done_next = pwr_done;
        init_idx_next = init_idx;
`endif
        case (state)
            ST_IDLE: begin
`ifdef LCD_CTRL_POWERON_INIT_EN
                if (!pwr_done) begin
                    state_next = ST_INIT;
                    cnt_next   = LD_POWERUP;
                end else if (init_idx != INIT_IDX_DONE) begin
                    out_next      = {1'b0, 1'b0, INIT_CMDS[init_idx[1:0]]};
                    init_idx_next = init_idx + 3'd1;
                    state_next    = ST_SETUP;
                    cnt_next      = LD_SETUP;
                end else if (!empty) begin
                    pop        = 1'b1;
                    out_next   = head;
                    state_next = ST_SETUP;
                    cnt_next   = LD_SETUP;
                end
`else
                if (!empty) begin
                    pop        = 1'b1;
                    out_next   = head;
                    state_next = ST_SETUP;
                    cnt_next   = LD_SETUP;
                end
`endif
            end
            ST_SETUP: begin
                if (cnt == '0) begin
                    state_next = ST_PULSE;
                    cnt_next   = LD_PULSE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_PULSE: begin
                if (cnt == '0) begin
                    state_next = ST_HOLD;
                    cnt_next   = LD_HOLD;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_next = ST_WAIT;
                    cnt_next   = is_long_cmd(out_q) ? LD_GAP_LONG : LD_GAP;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
`ifdef LCD_CTRL_POWERON_INIT_EN
            ST_INIT: begin
                if (cnt == '0) begin
                    state_next    = ST_IDLE;
                    pwr_done_next = 1'b1;
                end else begin
                    cnt_next = cnt - CW'(1);
                end
            end
`endif
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            out_q <= '0;
            tog_q <= 1'b0;
            on_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            out_q <= out_next;
            tog_q <= i_lcd_word[BIT_TOG];
            on_q  <= i_lcd_word[BIT_ON];
            ovf_q <= ovf_q | drop;
        end
    end

    assign o_lcd_data = out_q.data;
    assign o_lcd_rs   = out_q.rs;
    assign o_lcd_rw   = out_q.rw;
    assign o_lcd_en   = (state == ST_PULSE);
    assign o_lcd_on   = on_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Self-checking bench for lcd_ctrl: vector table with a per-cycle timing model,
// a scoreboard matched on every EN rising edge, and hand-written corner sequences.
module tb_lcd_ctrl;

    typedef struct packed {
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } xfer_t;

    typedef struct {
        logic        rs;
        logic        rw;
        logic [7:0]  data;
        int unsigned wait_cycles;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] word;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;
    logic        busy;
    logic        overflow;

    xfer_t       sb[$];
    xfer_t       mon_want;
    xfer_t       mon_cap;
    logic        en_prev = 1'b0;
    int unsigned total   = 0;
    int unsigned bad     = 0;
    int unsigned pulses  = 0;

    lcd_ctrl #(
        .T_SETUP    (2),
        .T_PULSE    (3),
        .T_HOLD     (1),
        .T_GAP      (5),
        .T_GAP_LONG (20),
        .T_POWERUP  (30)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_lcd_word (word),
        .o_lcd_data (lcd_data),
        .o_lcd_rs   (lcd_rs),
        .o_lcd_rw   (lcd_rw),
        .o_lcd_en   (lcd_en),
        .o_lcd_on   (lcd_on),
        .o_busy     (busy),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rs, input logic rw, input logic [7:0] data, input bit expect_xfer);
        word[9]   = rs;
        word[8]   = rw;
        word[7:0] = data;
        word[10]  = ~word[10];
        if (expect_xfer) begin
            sb.push_back({rs, rw, data});
        end
    endtask

    task automatic wait_idle(input int unsigned budget);
        bit done = 1'b0;
        for (int unsigned i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        check("idle_within_budget", done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_en"}, lcd_en, 0);
        check({tag, "_data"}, lcd_data, 0);
        check({tag, "_rs"}, lcd_rs, 0);
        check({tag, "_rw"}, lcd_rw, 0);
        check({tag, "_on"}, lcd_on, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, overflow, 0);
    endtask

    // Scoreboard: every EN rising edge must match the oldest expected transfer,
    // and the bus must not move while EN is high.
    always @(negedge clk) begin
        if (lcd_en && !en_prev) begin
            pulses++;
            check("pulse_expected", (sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_want = sb.pop_front();
                check("sb_data", lcd_data, mon_want.data);
                check("sb_rs", lcd_rs, mon_want.rs);
                check("sb_rw", lcd_rw, mon_want.rw);
            end
            mon_cap = {lcd_rs, lcd_rw, lcd_data};
        end else if (lcd_en) begin
            check("bus_stable_in_pulse", {lcd_rs, lcd_rw, lcd_data}, mon_cap);
        end
        en_prev <= lcd_en;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[8];
        int unsigned p0;
        int unsigned en_hi;
        int unsigned busy_lo;

        vecs[0] = '{1'b1, 1'b0, 8'h41, 5};
        vecs[1] = '{1'b0, 1'b0, 8'h01, 20};
        vecs[2] = '{1'b0, 1'b0, 8'h80, 5};
        vecs[3] = '{1'b0, 1'b0, 8'h02, 20};
        vecs[4] = '{1'b0, 1'b1, 8'h01, 5};
        vecs[5] = '{1'b1, 1'b0, 8'h01, 5};
        vecs[6] = '{1'b0, 1'b0, 8'h00, 5};
        vecs[7] = '{1'b1, 1'b1, 8'hFF, 5};

        // Reset state
        reset = 1'b1;
        word  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        reset = 1'b0;

`ifdef LCD_CTRL_POWERON_INIT_EN
        // Power-on init: silent power-up wait, four commands, then a queued user byte
        p0 = pulses;
        sb.push_back({1'b0, 1'b0, 8'h38});
        sb.push_back({1'b0, 1'b0, 8'h0C});
        sb.push_back({1'b0, 1'b0, 8'h01});
        sb.push_back({1'b0, 1'b0, 8'h06});
        en_hi   = 0;
        busy_lo = 0;
        for (int unsigned i = 0; i < 30; i++) begin
            @(negedge clk);
            if (lcd_en) en_hi++;
            if (!busy) busy_lo++;
            if (i == 5) send(1'b1, 1'b0, 8'h5A, 1'b1);
        end
        check("init_no_en_in_powerup", en_hi, 0);
        check("init_busy_in_powerup", busy_lo, 0);
        wait_idle(400);
        check("init_pulse_count", pulses - p0, 5);
        check("init_sb_drained", sb.size(), 0);
`endif

        // Table vectors with a cycle-exact timing model relative to the request cycle
        foreach (vecs[v]) begin
            step();
            send(vecs[v].rs, vecs[v].rw, vecs[v].data, 1'b1);
            for (int unsigned k = 0; k <= 8 + vecs[v].wait_cycles; k++) begin
                @(negedge clk);
                check($sformatf("v%0d_en_k%0d", v, k), lcd_en, (k >= 4 && k <= 6));
                check($sformatf("v%0d_busy_k%0d", v, k), busy,
                      (k >= 1 && k <= 7 + vecs[v].wait_cycles));
                if (k >= 2) begin
                    check($sformatf("v%0d_bus_k%0d", v, k), {lcd_rs, lcd_rw, lcd_data},
                          {vecs[v].rs, vecs[v].rw, vecs[v].data});
                end
            end
        end

        // Display-on bit bypasses the FIFO with one cycle of latency
        p0 = pulses;
        step();
        word[31] = 1'b1;
        @(negedge clk);
        check("on_latency_k0", lcd_on, 0);
        @(negedge clk);
        check("on_latency_k1", lcd_on, 1);
        repeat (8) @(negedge clk);
        check("on_no_pulse", pulses - p0, 0);
        check("on_not_busy", busy, 0);
        step();
        word[31] = 1'b0;
        @(negedge clk);
        check("off_latency_k0", lcd_on, 1);
        @(negedge clk);
        check("off_latency_k1", lcd_on, 0);

        // Six back-to-back requests: one popped at once, four buffered, sixth dropped
        p0 = pulses;
        for (int unsigned i = 0; i < 6; i++) begin
            step();
            send(1'b1, 1'b0, 8'(8'h10 + i), (i < 5));
        end
        @(negedge clk);
        check("ovf_before_drop", overflow, 0);
        @(negedge clk);
        check("ovf_after_drop", overflow, 1);
        wait_idle(300);
        check("burst_pulse_count", pulses - p0, 5);
        check("burst_sb_drained", sb.size(), 0);
        check("ovf_sticky", overflow, 1);
        step();
        reset = 1'b1;
        word  = '0;
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        check("ovf_cleared_by_reset", overflow, 0);
        check("busy_cleared_by_reset", busy, 0);
        step();
        reset = 1'b0;
`ifdef LCD_CTRL_POWERON_INIT_EN
        sb.push_back({1'b0, 1'b0, 8'h38});
        sb.push_back({1'b0, 1'b0, 8'h0C});
        sb.push_back({1'b0, 1'b0, 8'h01});
        sb.push_back({1'b0, 1'b0, 8'h06});
        wait_idle(400);
`endif

        // Reset in the second PULSE cycle aborts the transfer
        p0 = pulses;
        step();
        send(1'b1, 1'b0, 8'h55, 1'b1);
        repeat (5) @(negedge clk);
        check("abort_en_first_pulse", lcd_en, 1);
        step();
        check("abort_en_second_pulse", lcd_en, 1);
        reset = 1'b1;
        word  = '0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("abort");
        step();
        reset = 1'b0;
        sb.delete();
        repeat (25) @(negedge clk);
        check("abort_single_pulse", pulses - p0, 1);
        check("abort_en_low", lcd_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
